// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned ACK_MAX        = 4;
    localparam int unsigned GAP_CYCLES_DEF = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitAck,
        StWaitDone,
        StGap
    } arb_state_e;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte lanes plus the UART TX byte-engine handshake, bundled for the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = uart_arb_pkg::DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, with wrap-around.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             any
);
    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART TX byte engine among N_REQ sources.
// Optional inter-message idle gap is compiled in with UART_ARB_GAP_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
`ifdef UART_ARB_GAP_EN
    , parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.master        bus,
    output logic [N_REQ-1:0]         grant,
    output logic                     active
);
    localparam int unsigned PTR_W = $clog2(N_REQ);

    arb_state_e        state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [N_REQ-1:0]  grant_q;
    logic              active_q;
    logic              last_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
`ifdef UART_ARB_GAP_EN
    logic [15:0]       gap_cnt_q;
`endif

    logic [N_REQ-1:0]  pick_gnt;
    logic              pick_any;
    logic [DATA_W-1:0] lane_data;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              grant_valid;
    logic              grant_last;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) lane_data = lane_data | bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign grant_valid = |(bus.req_valid & grant_q);
    assign grant_last  = |(bus.req_last & grant_q);
    assign grant_idx   = PTR_W'(oh_to_idx(8'(grant_q)));
    assign next_ptr    = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_ARB_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q  <= pick_gnt;
                        active_q <= 1'b1;
                        state_q  <= StLoad;
                    end
                end
                // Only the owner is looked at here: the grant stays locked until its last byte.
                StLoad: begin
                    if (grant_valid) begin
                        tx_data_q  <= lane_data;
                        last_q     <= grant_last;
                        tx_start_q <= 1'b1;
                        state_q    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (bus.tx_busy) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            rr_ptr_q <= next_ptr;
                            grant_q  <= '0;
                            active_q <= 1'b0;
`ifdef UART_ARB_GAP_EN
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
`else
                            state_q   <= StIdle;
`endif
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
`ifdef UART_ARB_GAP_EN
                StGap: begin
                    if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StLoad) ? grant_q : '0;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign grant         = grant_q;
    assign active        = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART busy model and message sources.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned N        = 4;
    localparam int unsigned BUSY_LEN = 20;
    localparam int unsigned ACK_DLY  = ACK_MAX / 2;
`ifdef UART_ARB_GAP_EN
    localparam int unsigned GAP      = 10;
    localparam int unsigned EXP_ZRUN = GAP + 1;
`else
    localparam int unsigned EXP_ZRUN = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] grant;
    logic         active;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

`ifdef UART_ARB_GAP_EN
    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .grant  (grant),
        .active (active)
    );
`else
    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .grant  (grant),
        .active (active)
    );
`endif

    always #5 clk = ~clk;

    // Source messages: {last, data} per byte.
    logic [8:0]   mem [N][8];
    int           len [N];
    int           pos [N];
    logic [N-1:0] hold;

    logic [7:0]   log_data [64];
    logic [N-1:0] log_gnt  [64];
    int           log_n;

    int           cyc, n_checks, n_fail;
    int           start_cyc, busy_fall_cyc, act_fall_cyc, req_cyc;
    int           ack_cnt, busy_cnt, zero_cnt, zrun_len, n;
    logic         start_prev, active_prev;
    logic [N-1:0] gnt_seen, rdy_seen, zrun_gnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pending();
        for (int i = 0; i < N; i++) if (pos[i] < len[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < len[i] && !hold[i]) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[i*8 +: 8] = mem[i][pos[i]][7:0];
                bus.req_last[i]        = mem[i][pos[i]][8];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[i*8 +: 8] = 8'h00;
                bus.req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = bus.req_valid & bus.req_ready;
        if (bus.tx_start) begin
            chk("start_rule", {30'd0, start_prev, bus.tx_busy}, 32'd0);
            log_data[log_n] = bus.tx_data;
            log_gnt[log_n]  = grant;
            log_n++;
            start_cyc = cyc;
            ack_cnt   = ACK_DLY;
        end
        if (active_prev && !active) act_fall_cyc = cyc;
        if (grant == '0) begin
            zero_cnt++;
        end else if (zero_cnt != 0) begin
            zrun_len = zero_cnt;
            zrun_gnt = grant;
            zero_cnt = 0;
        end
        gnt_seen    = gnt_seen | grant;
        rdy_seen    = rdy_seen | bus.req_ready;
        start_prev  = bus.tx_start;
        active_prev = active;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            ack_cnt     = 0;
            busy_cnt    = 0;
            bus.tx_busy = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) if (fire[i]) pos[i]++;
            if (ack_cnt != 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    bus.tx_busy = 1'b1;
                    busy_cnt    = BUSY_LEN;
                end
            end else if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.tx_busy   = 1'b0;
                    busy_fall_cyc = cyc;
                end
            end
        end
        drive_lanes();
    endtask

    task automatic run_idle(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while ((active || bus.tx_busy || pending()) && k < budget);
        chk(tag, {31'd0, active || bus.tx_busy || pending()}, 32'd0);
        cycle();
    endtask

    task automatic push(input int r, input int idx, input logic [8:0] b);
        mem[r][idx] = b;
        if (idx == 0) pos[r] = 0;
        len[r] = idx + 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; log_n = 0;
        ack_cnt = 0; busy_cnt = 0; zero_cnt = 0; zrun_len = 0; zrun_gnt = '0;
        start_prev = 1'b0; active_prev = 1'b0; gnt_seen = '0; rdy_seen = '0;
        start_cyc = -1; busy_fall_cyc = 0; act_fall_cyc = 0; hold = '0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        bus.tx_busy = 1'b0;
        reset = 1'b1;
        drive_lanes();
        repeat (3) cycle();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        cycle();

        // "Hi" from requester 0.
        log_n = 0; gnt_seen = '0;
        push(0, 0, 9'h048); push(0, 1, 9'h169);
        run_idle("hi_done", 200);
        chk("hi_count", log_n, 2);
        chk("hi_b0", 32'(log_data[0]), 32'h48);
        chk("hi_b1", 32'(log_data[1]), 32'h69);
        chk("hi_gnt_all", 32'(gnt_seen), 32'h1);
        chk("hi_act_fall", act_fall_cyc - busy_fall_cyc, 1);

        // Requesters 1 and 3 together, pointer at 0 after reset.
        reset = 1'b1; cycle(); reset = 1'b0; cycle();
        log_n = 0;
        push(1, 0, 9'h031); push(1, 1, 9'h132);
        push(3, 0, 9'h041); push(3, 1, 9'h142);
        run_idle("rr13_done", 400);
        chk("rr13_count", log_n, 4);
        chk("rr13_seq", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h31324142);
        chk("rr13_gnt", 32'({log_gnt[0], log_gnt[1], log_gnt[2], log_gnt[3]}), 32'h2288);

        // Pointer is back at 0: requester 0 beats 1; then pointer at 2 so 3 beats 1.
        log_n = 0;
        push(0, 0, 9'h150); push(1, 0, 9'h151);
        run_idle("rr01_done", 300);
        chk("rr01_seq", {16'd0, log_data[0], log_data[1]}, 32'h5051);
        log_n = 0;
        push(1, 0, 9'h161); push(3, 0, 9'h163);
        run_idle("rr31_done", 300);
        chk("rr31_seq", {16'd0, log_data[0], log_data[1]}, 32'h6361);
        chk("rr31_gnt", 32'({log_gnt[0], log_gnt[1]}), 32'h82);

        // Requester 2 stalls mid-message while requester 0 waits.
        log_n = 0;
        push(2, 0, 9'h061); push(2, 1, 9'h062); push(2, 2, 9'h163);
        push(0, 0, 9'h170);
        n = 0;
        while (pos[2] < 1 && n < 30) begin
            cycle();
            n++;
        end
        chk("lock_first", pos[2], 1);
        hold[2] = 1'b1; gnt_seen = '0; rdy_seen = '0;
        repeat (50) cycle();
        chk("lock_gnt", 32'(gnt_seen), 32'h4);
        chk("lock_rdy", 32'(rdy_seen), 32'h4);
        chk("lock_log", log_n, 1);
        hold[2] = 1'b0;
        run_idle("lock_done", 400);
        chk("lock_seq", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h61626370);
        chk("lock_gnt_seq", 32'({log_gnt[0], log_gnt[1], log_gnt[2], log_gnt[3]}), 32'h4441);

        // Reset in WAIT_DONE, then a fresh request from the reset pointer.
        push(1, 0, 9'h021); push(1, 1, 9'h122);
        n = 0;
        while (!bus.tx_busy && n < 30) begin
            cycle();
            n++;
        end
        chk("mid_busy", 32'(bus.tx_busy), 32'd1);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) len[i] = pos[i];
        log_n = 0; start_cyc = -1;
        push(0, 0, 9'h1A0); push(1, 0, 9'h1A1);
        drive_lanes();
        req_cyc = cyc;
        n = 0;
        while (log_n == 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("post_rst_lat", start_cyc - req_cyc, 2);
        chk("post_rst_data", 32'(log_data[0]), 32'hA0);
        chk("post_rst_gnt", 32'(log_gnt[0]), 32'h1);
        run_idle("post_rst_done", 300);
        chk("post_rst_seq", {16'd0, log_data[0], log_data[1]}, 32'hA0A1);

        // Back-to-back single-byte messages: idle span between them.
        log_n = 0;
        push(2, 0, 9'h190); push(3, 0, 9'h191);
        run_idle("gap_done", 300);
        chk("gap_seq", {16'd0, log_data[0], log_data[1]}, 32'h9091);
        chk("gap_zero_run", zrun_len, EXP_ZRUN);
        chk("gap_next_gnt", 32'(zrun_gnt), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
